// File: rtl/pwr_mon_pkg.sv
// Shared types and helpers for the toggle activity monitor.
// Saturating add returns {overflow, clamped sum}.
package pwr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    ACCUM,
    REPORT
  } mon_state_t;

  localparam int unsigned SAT_W = 32;

  function automatic logic [SAT_W:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input logic [SAT_W-1:0] max
  );
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max}) begin
      return {1'b1, max};
    end
    return {1'b0, sum[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/net_popcount.sv
// Combinational population count of a bit vector.
// Output width is just wide enough to hold W.
module net_popcount #(
  parameter int W = 5
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Windowed toggle / signal-probability monitor for a net vector.
// Reports one record per window over a valid/ready handshake.
module toggle_activity_monitor
  import pwr_mon_pkg::*;
#(
  parameter int NUM_NETS = 5,
  parameter int WINDOW   = 256,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sample_valid,
  input  logic [NUM_NETS-1:0] net_in,
  output logic                busy,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [CNT_W-1:0]    rpt_toggles,
  output logic [CNT_W-1:0]    rpt_ones,
  output logic                rpt_sat,
  output logic                rpt_overrun
);

  localparam int PW = $clog2(NUM_NETS + 1);
  localparam int SW = $clog2(WINDOW + 1);
  localparam logic [SAT_W-1:0] MAXV =
    SAT_W'((64'd1 << CNT_W) - 64'd1);

  mon_state_t          state;
  logic [NUM_NETS-1:0] prev;
  logic [SW-1:0]       scnt;
  logic [SW-1:0]       scnt_nx;
  logic [PW-1:0]       pc;
  logic [SAT_W:0]      tog_sum;
  logic [SAT_W:0]      one_sum;
  logic                unused_bits;

  net_popcount #(.W(NUM_NETS)) u_pc (
    .vec (net_in ^ prev),
    .cnt (pc)
  );

  always_comb begin
    tog_sum = sat_add(SAT_W'(rpt_toggles), SAT_W'(pc), MAXV);
    one_sum = sat_add(SAT_W'(rpt_ones),
                      SAT_W'(net_in[NUM_NETS-1]), MAXV);
    scnt_nx = scnt + SW'(1);
  end

  assign unused_bits = ^{tog_sum, one_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev        <= '0;
      scnt        <= '0;
      busy        <= 1'b0;
      rpt_valid   <= 1'b0;
      rpt_toggles <= '0;
      rpt_ones    <= '0;
      rpt_sat     <= 1'b0;
      rpt_overrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= PRIME;
            busy        <= 1'b1;
            scnt        <= '0;
            rpt_toggles <= '0;
            rpt_ones    <= '0;
            rpt_sat     <= 1'b0;
            rpt_overrun <= 1'b0;
          end
        end
        PRIME: begin
          // First sample only seeds prev; no toggle is counted.
          if (sample_valid) begin
            state    <= ACCUM;
            prev     <= net_in;
            rpt_ones <= one_sum[CNT_W-1:0];
            rpt_sat  <= rpt_sat | one_sum[SAT_W];
            scnt     <= SW'(1);
          end
        end
        ACCUM: begin
          if (sample_valid) begin
            prev        <= net_in;
            rpt_toggles <= tog_sum[CNT_W-1:0];
            rpt_ones    <= one_sum[CNT_W-1:0];
            rpt_sat     <= rpt_sat | tog_sum[SAT_W]
                           | one_sum[SAT_W];
            scnt        <= scnt_nx;
            if (scnt_nx == SW'(WINDOW)) begin
              state     <= REPORT;
              rpt_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (sample_valid) begin
            rpt_overrun <= 1'b1;
          end
          if (rpt_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rpt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Scoreboard bench: a window model pushes expected records,
// a monitor pops and compares them on each report handshake.
module tb_toggle_activity_monitor;

  typedef struct {
    int tog;
    int ones;
    bit sat;
    bit ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start_s;
  logic       sample_valid;
  logic [4:0] net_in;
  logic       rpt_ready;

  logic        busy_m, rpt_valid_m, rpt_sat_m, rpt_overrun_m;
  logic [15:0] rpt_toggles_m, rpt_ones_m;
  logic        busy_s, rpt_valid_s, rpt_sat_s, rpt_overrun_s;
  logic [3:0]  rpt_toggles_s, rpt_ones_s;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_m[$];
  exp_t q_s[$];
  logic [4:0] pat[8];

  always #5 clk = ~clk;

  toggle_activity_monitor #(
    .NUM_NETS(5), .WINDOW(4), .CNT_W(16)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .sample_valid (sample_valid),
    .net_in       (net_in),
    .busy         (busy_m),
    .rpt_valid    (rpt_valid_m),
    .rpt_ready    (rpt_ready),
    .rpt_toggles  (rpt_toggles_m),
    .rpt_ones     (rpt_ones_m),
    .rpt_sat      (rpt_sat_m),
    .rpt_overrun  (rpt_overrun_m)
  );

  toggle_activity_monitor #(
    .NUM_NETS(5), .WINDOW(6), .CNT_W(4)
  ) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_s),
    .sample_valid (sample_valid),
    .net_in       (net_in),
    .busy         (busy_s),
    .rpt_valid    (rpt_valid_s),
    .rpt_ready    (rpt_ready),
    .rpt_toggles  (rpt_toggles_s),
    .rpt_ones     (rpt_ones_s),
    .rpt_sat      (rpt_sat_s),
    .rpt_overrun  (rpt_overrun_s)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] s[8],
                                 input int n, input int maxv,
                                 input bit ovr);
    exp_t e;
    e.tog = 0;
    e.ones = 0;
    e.sat = 1'b0;
    e.ovr = ovr;
    for (int i = 0; i < n; i++) begin
      if (s[i][4]) e.ones++;
      if (i > 0) e.tog += $countones(s[i] ^ s[i-1]);
      if (e.tog > maxv) begin e.tog = maxv; e.sat = 1'b1; end
      if (e.ones > maxv) begin e.ones = maxv; e.sat = 1'b1; end
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rpt_valid_m && rpt_ready) begin
      if (q_m.size() == 0) check("m_unexpected", 1, 0);
      else begin
        e = q_m.pop_front();
        check("m_toggles", rpt_toggles_m, e.tog);
        check("m_ones", rpt_ones_m, e.ones);
        check("m_sat", rpt_sat_m, e.sat);
        check("m_overrun", rpt_overrun_m, e.ovr);
      end
    end
    if (rst_n && rpt_valid_s && rpt_ready) begin
      if (q_s.size() == 0) check("s_unexpected", 1, 0);
      else begin
        e = q_s.pop_front();
        check("s_toggles", rpt_toggles_s, e.tog);
        check("s_ones", rpt_ones_s, e.ones);
        check("s_sat", rpt_sat_s, e.sat);
        check("s_overrun", rpt_overrun_s, e.ovr);
      end
    end
  end

  task automatic do_start(input bit which);
    if (which) start_s = 1'b1;
    else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic send(input logic [4:0] v);
    sample_valid = 1'b1;
    net_in = v;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit which);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = which ? rpt_valid_s : rpt_valid_m;
    end
    if (!got) check("valid_timeout", 0, 1);
  endtask

  task automatic hs();
    @(posedge clk); #1;
    rpt_ready = 1'b1;
    @(posedge clk); #1;
    rpt_ready = 1'b0;
    @(negedge clk);
    check("hs_valid_low", rpt_valid_m | rpt_valid_s, 0);
    check("hs_idle", busy_m | busy_s, 0);
  endtask

  task automatic run_main(input bit ovr);
    q_m.push_back(model(pat, 4, 65535, ovr));
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(pat[i]);
  endtask

  task automatic set_pat(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] d);
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
    pat[4] = b; pat[5] = a; pat[6] = '0; pat[7] = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    sample_valid = 1'b0;
    net_in = '0;
    rpt_ready = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy_m, 0);
    check("rst_valid", rpt_valid_m, 0);
    check("rst_rpt", {rpt_toggles_m, rpt_ones_m,
                      14'd0, rpt_sat_m, rpt_overrun_m}, 0);
    check("rst_sat_dut", {busy_s, rpt_valid_s, rpt_toggles_s}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy_m, 0);
    check("idle_valid", rpt_valid_m, 0);
    check("idle_rpt", {rpt_toggles_m, rpt_ones_m}, 0);

    // All-zero window with latency check
    set_pat(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    q_m.push_back(model(pat, 4, 65535, 1'b0));
    do_start(1'b0);
    check("busy_after_start", busy_m, 1);
    for (int i = 0; i < 3; i++) send(pat[i]);
    @(negedge clk);
    check("valid_early", rpt_valid_m, 0);
    send(pat[3]);
    @(negedge clk);
    check("valid_latency", rpt_valid_m, 1);
    hs();

    // Full toggling, ready already high
    rpt_ready = 1'b1;
    set_pat(5'b11111, 5'b00000, 5'b11111, 5'b00000);
    run_main(1'b0);
    @(posedge clk); #1;
    rpt_ready = 1'b0;
    @(negedge clk);
    check("t3_idle_busy", busy_m, 0);
    check("t3_idle_valid", rpt_valid_m, 0);

    // Back-pressure with samples arriving during REPORT
    run_main(1'b1);
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", rpt_valid_m, 1);
      check("hold_toggles", rpt_toggles_m, 15);
      check("hold_ones", rpt_ones_m, 2);
    end
    sample_valid = 1'b0;
    hs();
    set_pat(5'b10101, 5'b10101, 5'b01010, 5'b00000);
    run_main(1'b0);
    wait_valid(1'b0);
    hs();

    // start and sample together in IDLE: sample not captured
    set_pat(5'b00000, 5'b00000, 5'b00000, 5'b00000);
    q_m.push_back(model(pat, 4, 65535, 1'b0));
    start = 1'b1;
    sample_valid = 1'b1;
    net_in = 5'b11111;
    @(posedge clk); #1;
    start = 1'b0;
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(pat[i]);
    wait_valid(1'b0);
    hs();

    // Saturation on a 4-bit, 6-sample instance
    for (int i = 0; i < 6; i++) pat[i] = (i % 2 == 0) ? 5'h1f : 5'h00;
    q_s.push_back(model(pat, 6, 15, 1'b0));
    do_start(1'b1);
    for (int i = 0; i < 6; i++) send(pat[i]);
    wait_valid(1'b1);
    check("sat_main_idle", busy_m, 0);
    hs();

    // start ignored during ACCUM and REPORT
    set_pat(5'b11111, 5'b00000, 5'b00000, 5'b11111);
    q_m.push_back(model(pat, 4, 65535, 1'b0));
    do_start(1'b0);
    send(pat[0]);
    send(pat[1]);
    do_start(1'b0);
    send(pat[2]);
    send(pat[3]);
    wait_valid(1'b0);
    do_start(1'b0);
    @(negedge clk);
    check("start_in_report", rpt_valid_m, 1);
    check("start_in_report_tog", rpt_toggles_m, 10);
    hs();

    // Asynchronous reset mid-window discards everything
    do_start(1'b0);
    send(5'b11111);
    send(5'b00000);
    send(5'b11111);
    @(negedge clk);
    check("pre_rst_busy", busy_m, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", busy_m, 0);
    check("async_tog", rpt_toggles_m, 0);
    check("async_ones", rpt_ones_m, 0);
    check("async_valid", rpt_valid_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy_m, 0);
    set_pat(5'b00001, 5'b10000, 5'b10001, 5'b00011);
    run_main(1'b0);
    wait_valid(1'b0);
    hs();

    check("q_m_drained", q_m.size(), 0);
    check("q_s_drained", q_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
